// File: rtl/cpu_if.sv
// Program-memory fetch bus between the interpreter core and its ROM.
// The ROM answers a window request one clock after it sees the address.
interface cpu_if #(
   parameter int unsigned MEM_DEPTH = 4
);
   logic [MEM_DEPTH:0] mem_addr;
   logic [3:0]         mem_extra;
   logic [127:0]       mem_data;
   logic               mem_error;

   modport master (
      output mem_addr,
      output mem_extra,
      input  mem_data,
      input  mem_error
   );

   modport slave (
      input  mem_addr,
      input  mem_extra,
      output mem_data,
      output mem_error
   );
endinterface

// File: rtl/cpu.sv
// WebAssembly bytecode interpreter: FETCH/EXEC/HALT loop over a 16-byte fetch window,
// typed 64-bit operand stack, reports top of stack or a trap code when it stops.
module cpu #(
   parameter int unsigned MEM_DEPTH   = 4,
   parameter int unsigned STACK_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   cpu_if.master       mem,
   output logic [63:0] result,
   output logic [1:0]  result_type,
   output logic        result_empty,
   output logic [3:0]  trap
);

   localparam int unsigned PcW  = MEM_DEPTH + 1;
   localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
   localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [1:0] TyI32 = 2'd0;
   localparam logic [1:0] TyI64 = 2'd1;

   localparam logic [3:0] TrapRun       = 4'd0;
   localparam logic [3:0] TrapEnd       = 4'd1;
   localparam logic [3:0] TrapUnreach   = 4'd2;
   localparam logic [3:0] TrapIllegal   = 4'd3;
   localparam logic [3:0] TrapOverflow  = 4'd4;
   localparam logic [3:0] TrapUnderflow = 4'd5;
   localparam logic [3:0] TrapMem       = 4'd6;
   localparam logic [3:0] TrapType      = 4'd7;

   localparam logic [7:0] OpUnreach  = 8'h00;
   localparam logic [7:0] OpNop      = 8'h01;
   localparam logic [7:0] OpEnd      = 8'h0B;
   localparam logic [7:0] OpReturn   = 8'h0F;
   localparam logic [7:0] OpDrop     = 8'h1A;
   localparam logic [7:0] OpI32Const = 8'h41;
   localparam logic [7:0] OpI64Const = 8'h42;
   localparam logic [7:0] OpI32Add   = 8'h6A;
   localparam logic [7:0] OpI64Add   = 8'h7C;

   typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

   state_e         state_q;
   logic [PcW-1:0] pc_q;
   logic [SpW-1:0] sp_q;

   logic [63:0] stack_val  [STACK_DEPTH];
   logic [1:0]  stack_type [STACK_DEPTH];

   function automatic logic [7:0] win_byte(input logic [127:0] win, input int idx);
      return win[127 - 8 * idx -: 8];
   endfunction

   assign mem.mem_addr  = pc_q;
   assign mem.mem_extra = 4'd10;

   // Signed LEB128 immediate following the opcode byte.
   logic [7:0]  opcode;
   logic [7:0]  leb_byte;
   logic [63:0] leb_val;
   logic [3:0]  leb_len;
   logic        leb_ok;
   int          leb_max;

   always_comb begin
      opcode   = win_byte(mem.mem_data, 0);
      leb_max  = (opcode == OpI64Const) ? 10 : 5;
      leb_byte = '0;
      leb_val  = '0;
      leb_len  = '0;
      leb_ok   = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (!leb_ok && i < leb_max) begin
            leb_byte = win_byte(mem.mem_data, i + 1);
            for (int k = 0; k < 7; k++) begin
               if (7 * i + k < 64) leb_val[7 * i + k] = leb_byte[k];
            end
            if (!leb_byte[7]) begin
               leb_ok  = 1'b1;
               leb_len = 4'(i + 1);
               if (leb_byte[6]) leb_val = leb_val | (~64'd0 << (7 * (i + 1)));
            end
         end
      end
   end

   logic [IdxW-1:0] idx_top;
   logic [IdxW-1:0] idx_sec;
   logic [63:0]     top_val;
   logic [63:0]     sec_val;
   logic [1:0]      top_type;
   logic [1:0]      sec_type;

   assign idx_top  = IdxW'(sp_q - SpW'(1));
   assign idx_sec  = IdxW'(sp_q - SpW'(2));
   assign top_val  = stack_val[idx_top];
   assign sec_val  = stack_val[idx_sec];
   assign top_type = stack_type[idx_top];
   assign sec_type = stack_type[idx_sec];

   logic            stack_full;
   logic [3:0]      ex_trap;
   logic            ex_end;
   logic [3:0]      ex_len;
   logic            ex_push;
   logic [IdxW-1:0] ex_idx;
   logic [63:0]     ex_val;
   logic [1:0]      ex_type;
   logic [SpW-1:0]  ex_sp;
   logic            wr_en;

   assign stack_full = (sp_q == SpW'(STACK_DEPTH));

   always_comb begin
      ex_trap = TrapRun;
      ex_end  = 1'b0;
      ex_len  = 4'd1;
      ex_push = 1'b0;
      ex_idx  = IdxW'(sp_q);
      ex_val  = '0;
      ex_type = TyI32;
      ex_sp   = sp_q;
      case (opcode)
         OpUnreach: ex_trap = TrapUnreach;
         OpNop:     ex_len  = 4'd1;
         OpEnd, OpReturn: ex_end = 1'b1;
         OpDrop: begin
            if (sp_q == '0) ex_trap = TrapUnderflow;
            else            ex_sp   = sp_q - SpW'(1);
         end
         OpI32Const, OpI64Const: begin
            ex_len  = leb_len + 4'd1;
            ex_push = 1'b1;
            ex_sp   = sp_q + SpW'(1);
            if (opcode == OpI32Const) begin
               ex_val  = {32'd0, leb_val[31:0]};
               ex_type = TyI32;
            end else begin
               ex_val  = leb_val;
               ex_type = TyI64;
            end
            // Unterminated immediate within its length limit is malformed code.
            if (!leb_ok)         ex_trap = TrapIllegal;
            else if (stack_full) ex_trap = TrapOverflow;
         end
         OpI32Add, OpI64Add: begin
            ex_push = 1'b1;
            ex_idx  = idx_sec;
            ex_sp   = sp_q - SpW'(1);
            if (opcode == OpI32Add) begin
               ex_type = TyI32;
               ex_val  = {32'd0, sec_val[31:0] + top_val[31:0]};
            end else begin
               ex_type = TyI64;
               ex_val  = sec_val + top_val;
            end
            if (sp_q < SpW'(2))                                ex_trap = TrapUnderflow;
            else if (top_type != ex_type || sec_type != ex_type) ex_trap = TrapType;
         end
         default: ex_trap = TrapIllegal;
      endcase
   end

   assign wr_en = (state_q == StExec) && !mem.mem_error && (ex_trap == TrapRun) && ex_push;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         stack_val[ex_idx]  <= ex_val;
         stack_type[ex_idx] <= ex_type;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StFetch;
         pc_q         <= '0;
         sp_q         <= '0;
         result       <= '0;
         result_type  <= TyI32;
         result_empty <= 1'b1;
         trap         <= TrapRun;
      end else begin
         case (state_q)
            StFetch: state_q <= StExec;
            StExec: begin
               if (mem.mem_error) begin
                  trap    <= TrapMem;
                  state_q <= StHalt;
               end else if (ex_trap != TrapRun) begin
                  trap    <= ex_trap;
                  state_q <= StHalt;
               end else if (ex_end) begin
                  if (sp_q == '0) begin
                     result       <= '0;
                     result_type  <= TyI32;
                     result_empty <= 1'b1;
                  end else begin
                     result       <= top_val;
                     result_type  <= top_type;
                     result_empty <= 1'b0;
                  end
                  trap    <= TrapEnd;
                  state_q <= StHalt;
               end else begin
                  pc_q    <= pc_q + PcW'(ex_len);
                  sp_q    <= ex_sp;
                  state_q <= StFetch;
               end
            end
            default: state_q <= StHalt;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the interpreter: registered ROM model, expected outcomes
// queued per program and popped when the core halts.
module tb_cpu;
   localparam int unsigned MemDepth = 6;
   localparam int          RomSize  = 128;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic [63:0] result;
   logic [1:0]  result_type;
   logic        result_empty;
   logic [3:0]  trap;

   cpu_if #(.MEM_DEPTH(MemDepth)) bus ();

   cpu #(
      .MEM_DEPTH  (MemDepth),
      .STACK_DEPTH(16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .mem         (bus),
      .result      (result),
      .result_type (result_type),
      .result_empty(result_empty),
      .trap        (trap)
   );

   always #5 clk = ~clk;

   logic [7:0] rom [RomSize];
   logic       force_err = 1'b0;
   int         rom_a;

   always @(posedge clk) begin
      for (int i = 0; i < 16; i++) begin
         rom_a = int'(bus.mem_addr) + i;
         bus.mem_data[127 - 8 * i -: 8] <= (rom_a < RomSize) ? rom[7'(rom_a)] : 8'h00;
      end
      bus.mem_error <= force_err || (int'(bus.mem_addr) + int'(bus.mem_extra) >= RomSize);
   end

   typedef struct {
      string       tag;
      logic [3:0]  trap;
      logic [63:0] res;
      logic [1:0]  ty;
      logic        empty;
   } exp_t;

   exp_t       sb[$];
   logic [7:0] prog[$];
   int         n_assert = 0;
   int         n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, ".rst.trap"}, 64'(trap), 64'd0);
      check({tag, ".rst.result"}, result, 64'd0);
      check({tag, ".rst.type"}, 64'(result_type), 64'd0);
      check({tag, ".rst.empty"}, 64'(result_empty), 64'd1);
      check({tag, ".rst.addr"}, 64'(bus.mem_addr), 64'd0);
      check({tag, ".rst.extra"}, 64'(bus.mem_extra), 64'd10);
   endtask

   // Load prog, hold reset for a cycle, then run until the core reports a trap.
   task automatic run(input string tag, input logic [3:0] t, input logic [63:0] r,
                      input logic [1:0] ty, input logic e, input int budget);
      exp_t x;
      int   cyc;
      for (int i = 0; i < RomSize; i++) rom[i] = (i < prog.size()) ? prog[i] : 8'h00;
      reset = 1'b0;
      @(negedge clk);
      check_reset_state(tag);
      x.tag = tag; x.trap = t; x.res = r; x.ty = ty; x.empty = e;
      sb.push_back(x);
      @(negedge clk);
      reset = 1'b1;
      cyc = 0;
      while (trap === 4'd0 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      x = sb.pop_front();
      check({x.tag, ".latency_ok"}, 64'(cyc <= budget), 64'd1);
      check({x.tag, ".trap"}, 64'(trap), 64'(x.trap));
      check({x.tag, ".result"}, result, x.res);
      check({x.tag, ".type"}, 64'(result_type), 64'(x.ty));
      check({x.tag, ".empty"}, 64'(result_empty), 64'(x.empty));
      repeat (4) @(posedge clk);
      #1;
      check({x.tag, ".halt.trap"}, 64'(trap), 64'(x.trap));
      check({x.tag, ".halt.result"}, result, x.res);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      prog = '{8'h42, 8'h2A, 8'h0F};
      run("i64_42", 4'd1, 64'd42, 2'd1, 1'b0, 6);

      prog = '{8'h41, 8'h7F, 8'h0B};
      run("i32_m1", 4'd1, 64'h0000_0000_FFFF_FFFF, 2'd0, 1'b0, 50);

      prog = '{8'h41, 8'h02, 8'h41, 8'h03, 8'h6A, 8'h0F};
      run("i32_add", 4'd1, 64'd5, 2'd0, 1'b0, 50);

      prog = '{8'h41, 8'h01, 8'h42, 8'h01, 8'h6A, 8'h0F};
      run("add_mix", 4'd7, 64'd0, 2'd0, 1'b1, 50);

      prog = '{8'h0F};
      run("empty_ret", 4'd1, 64'd0, 2'd0, 1'b1, 50);

      prog = '{8'h1A};
      run("drop_empty", 4'd5, 64'd0, 2'd0, 1'b1, 50);

      prog = '{8'h00};
      run("unreach", 4'd2, 64'd0, 2'd0, 1'b1, 50);

      prog = '{8'hFF};
      run("illegal", 4'd3, 64'd0, 2'd0, 1'b1, 50);

      prog = '{8'h42, 8'h80, 8'h01, 8'h0F};
      run("leb_128", 4'd1, 64'd128, 2'd1, 1'b0, 50);

      prog = '{8'h42, 8'h7F, 8'h0F};
      run("i64_m1", 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b0, 50);

      prog = '{8'h42, 8'h7F, 8'h42, 8'h01, 8'h7C, 8'h0F};
      run("i64_wrap", 4'd1, 64'd0, 2'd1, 1'b0, 50);

      prog = '{8'h41, 8'h7F, 8'h41, 8'h01, 8'h6A, 8'h0B};
      run("i32_wrap", 4'd1, 64'd0, 2'd0, 1'b0, 50);

      prog = '{8'h01, 8'h41, 8'h05, 8'h41, 8'h06, 8'h1A, 8'h0F};
      run("nop_drop", 4'd1, 64'd5, 2'd0, 1'b0, 50);

      prog = '{8'h6A};
      run("add_under", 4'd5, 64'd0, 2'd0, 1'b1, 50);

      prog = {};
      for (int i = 0; i < 17; i++) begin
         prog.push_back(8'h41);
         prog.push_back(8'(i));
      end
      prog.push_back(8'h0F);
      run("overflow", 4'd4, 64'd0, 2'd0, 1'b1, 150);

      force_err = 1'b1;
      prog = '{8'h01, 8'h0F};
      run("mem_err", 4'd6, 64'd0, 2'd0, 1'b1, 50);
      force_err = 1'b0;

      // Reset partway through 42 2A 0F, after the push has landed.
      prog = '{8'h42, 8'h2A, 8'h0F};
      for (int i = 0; i < RomSize; i++) rom[i] = (i < prog.size()) ? prog[i] : 8'h00;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid.addr_before", 64'(bus.mem_addr), 64'd2);
      check("mid.trap_before", 64'(trap), 64'd0);
      #2;
      reset = 1'b0;
      #1;
      check_reset_state("mid");
      run("mid_rerun", 4'd1, 64'd42, 2'd1, 1'b0, 6);

      // A pushed value must not survive reset into a program that returns immediately.
      prog = '{8'h41, 8'h07, 8'h0B};
      for (int i = 0; i < RomSize; i++) rom[i] = (i < prog.size()) ? prog[i] : 8'h00;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #2;
      prog = '{8'h0F};
      run("discard", 4'd1, 64'd0, 2'd0, 1'b1, 50);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter MEM_DEPTH, default 4, meaning program-memory address width minus one (mem_addr is MEM_DEPTH+1 bits).
REQ-002 Parameter STACK_DEPTH, default 16, meaning number of operand-stack entries.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 result  output  64  value on top of stack at program end.
REQ-007 result_type  output  2  type of result: i32=0, i64=1, f32=2, f64=3.
REQ-008 result_empty  output  1  high when the stack held no value at program end.
REQ-009 trap  output  4  status: 0 running, 1 ended, 2 unreachable, 3 illegal opcode, 4 stack overflow, 5 stack underflow, 6 memory error, 7 type mismatch.
REQ-010 mem_addr  output  MEM_DEPTH+1  byte address of fetch window.
REQ-011 mem_extra  output  4  extra bytes requested beyond the first; constant 10.
REQ-012 mem_data  input  128  fetch window; byte at mem_addr+i is mem_data[127-8i -: 8].
REQ-013 mem_error  input  1  requested window out of bounds.

Function
REQ-014 Program memory (genrom) returns mem_data and mem_error registered one clock after mem_addr/mem_extra are presented.
REQ-015 CPU is a WebAssembly bytecode interpreter; pc starts at 0; states FETCH (drive mem_addr=pc), EXEC (decode window), HALT.
REQ-016 FETCH always moves to EXEC next cycle; EXEC executes one instruction, sets pc += instruction length, returns to FETCH, or enters HALT.
REQ-017 mem_error high in EXEC -> trap=6, HALT.
REQ-018 Opcodes: 0x00 unreachable -> trap=2, HALT; 0x01 nop; 0x0B end and 0x0F return -> program end; 0x1A drop pops one.
REQ-019 0x41 i32.const: signed LEB128 immediate, up to 5 bytes; push low 32 bits zero-extended to 64, type i32.
REQ-020 0x42 i64.const: signed LEB128 immediate, up to 10 bytes; push sign-extended 64-bit value, type i64.
REQ-021 0x6A i32.add and 0x7C i64.add: pop two, push wraparound sum (i32 result zero-extended); both operands not of matching type -> trap=7.
REQ-022 Any other opcode -> trap=3, HALT.
REQ-023 Push with stack full -> trap=4; pop with insufficient entries -> trap=5; both HALT without modifying stack.
REQ-024 Program end: stack non-empty -> result=top value, result_type=top type, result_empty=0; empty -> result=0, result_type=0, result_empty=1; trap=1; HALT.
REQ-025 On trap other than 1, result/result_type/result_empty keep reset values.
REQ-026 HALT is absorbing until reset; no further fetches change outputs.
REQ-027 Program "i64.const 42; return" reaches HALT with outputs valid by the 6th rising clock edge after reset release.

Reset
REQ-028 reset low asynchronously sets pc=0, stack pointer=0, state=FETCH, mem_addr=0, mem_extra=10, result=0, result_type=0, result_empty=1, trap=0.
REQ-029 Reset asserted mid-program discards all stack contents; execution restarts from pc 0 after release.

Verification
REQ-030 ROM 42 2A 0F -> result=42, result_type=1, result_empty=0, trap=1 by 6th edge.
REQ-031 ROM 41 7F 0B -> result=0x00000000FFFFFFFF, result_type=0, trap=1.
REQ-032 ROM 41 02 41 03 6A 0F -> result=5, result_type=0; ROM 41 01 42 01 6A 0F -> trap=7.
REQ-033 ROM 0F -> result_empty=1, result=0, trap=1; ROM 1A -> trap=5; ROM 00 -> trap=2; ROM FF -> trap=3.
REQ-034 Seventeen consecutive i32.const then 0F -> trap=4.
REQ-035 Assert reset during execution of 42 2A 0F, release -> outputs return to reset values, then same end result as REQ-030.
